// File: rtl/bgpu_pkg.sv
// Shared GPU core types: the dispatched instruction encoding and the
// operand collector FSM states.
package bgpu_pkg;

  typedef struct packed {
    logic [3:0] eu;
    logic [7:0] subtype;
  } inst_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } opc_state_e;

endpackage

// File: rtl/operand_collector.sv
// Per-lane operand collector: latches one dispatched instruction, gathers its
// register operands through independent RF ports, then issues it to the EU.
module operand_collector
  import bgpu_pkg::*;
#(
  parameter int NumTags         = 8,
  parameter int NumWarps        = 8,
  parameter int PcWidth         = 32,
  parameter int WarpWidth       = 32,
  parameter int RegIdxWidth     = 6,
  parameter int OperandsPerInst = 2,
  parameter int RegWidth        = 32,
  localparam int TagWidth       = $clog2(NumTags),
  localparam int WidWidth       = NumWarps > 1 ? $clog2(NumWarps) : 1,
  localparam int IidWidth       = TagWidth + WidWidth,
  localparam int OpdWidth       = WarpWidth * RegWidth
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,

  output logic                                    opc_ready_o,
  input  logic                                    disp_valid_i,
  input  logic [IidWidth-1:0]                     disp_tag_i,
  input  logic [PcWidth-1:0]                      disp_pc_i,
  input  logic [WarpWidth-1:0]                    disp_act_mask_i,
  input  inst_t                                   disp_inst_i,
  input  logic [RegIdxWidth-1:0]                  disp_dst_i,
  input  logic [OperandsPerInst-1:0]              disp_operands_is_reg_i,
  input  logic [OperandsPerInst*RegIdxWidth-1:0]  disp_operands_i,

  output logic [OperandsPerInst-1:0]              rf_req_valid_o,
  input  logic [OperandsPerInst-1:0]              rf_req_ready_i,
  output logic [OperandsPerInst*WidWidth-1:0]     rf_req_wid_o,
  output logic [OperandsPerInst*RegIdxWidth-1:0]  rf_req_idx_o,
  input  logic [OperandsPerInst-1:0]              rf_rsp_valid_i,
  input  logic [OperandsPerInst*OpdWidth-1:0]     rf_rsp_data_i,

  output logic                                    eu_valid_o,
  input  logic                                    eu_ready_i,
  output logic [IidWidth-1:0]                     eu_tag_o,
  output logic [PcWidth-1:0]                      eu_pc_o,
  output logic [WarpWidth-1:0]                    eu_act_mask_o,
  output inst_t                                   eu_inst_o,
  output logic [RegIdxWidth-1:0]                  eu_dst_o,
  output logic [OperandsPerInst*OpdWidth-1:0]     eu_operands_o,

  output logic                                    opc_eu_handshake_o,
  output logic [IidWidth-1:0]                     opc_eu_tag_o
);

  opc_state_e                   state_q;
  logic [IidWidth-1:0]          tag_q;
  logic [PcWidth-1:0]           pc_q;
  logic [WarpWidth-1:0]         act_mask_q;
  inst_t                        inst_q;
  logic [RegIdxWidth-1:0]       dst_q;
  logic [OperandsPerInst-1:0]   pending;
  logic                         disp_fire;

  assign opc_ready_o = (state_q == IDLE);
  assign disp_fire   = disp_valid_i && (state_q == IDLE);

  // Control FSM and latched instruction fields
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tag_q      <= '0;
      pc_q       <= '0;
      act_mask_q <= '0;
      inst_q     <= '0;
      dst_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (disp_valid_i) begin
            tag_q      <= disp_tag_i;
            pc_q       <= disp_pc_i;
            act_mask_q <= disp_act_mask_i;
            inst_q     <= disp_inst_i;
            dst_q      <= disp_dst_i;
            state_q    <= (|disp_operands_is_reg_i) ? COLLECT : ISSUE;
          end
        end
        COLLECT: begin
          // pending clears on the response edge; ISSUE follows one edge later
          if (pending == '0) state_q <= ISSUE;
        end
        ISSUE: begin
          if (eu_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-operand request / response tracking
  for (genvar o = 0; o < OperandsPerInst; o++) begin : g_opd
    logic                   pend_q;
    logic                   req_q;
    logic [RegIdxWidth-1:0] idx_q;
    logic [OpdWidth-1:0]    data_q;
    logic [RegIdxWidth-1:0] disp_idx;
    logic [RegWidth-1:0]    imm;
    logic                   req_fire;
    logic                   rsp_take;

    assign disp_idx = disp_operands_i[o*RegIdxWidth +: RegIdxWidth];
    assign imm      = RegWidth'(disp_idx);
    assign req_fire = rf_req_valid_o[o] && rf_req_ready_i[o];
    assign rsp_take = (state_q == COLLECT) && rf_rsp_valid_i[o] && pend_q && req_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pend_q <= 1'b0;
        req_q  <= 1'b0;
        idx_q  <= '0;
        data_q <= '0;
      end else if (disp_fire) begin
        pend_q <= disp_operands_is_reg_i[o];
        req_q  <= 1'b0;
        idx_q  <= disp_idx;
        if (!disp_operands_is_reg_i[o]) data_q <= {WarpWidth{imm}};
      end else begin
        if (req_fire) req_q <= 1'b1;
        if (rsp_take) begin
          pend_q <= 1'b0;
          data_q <= rf_rsp_data_i[o*OpdWidth +: OpdWidth];
        end
      end
    end

    assign pending[o]                                 = pend_q;
    assign rf_req_valid_o[o]                          = (state_q == COLLECT) && pend_q && !req_q;
    assign rf_req_idx_o[o*RegIdxWidth +: RegIdxWidth] = idx_q;
    assign rf_req_wid_o[o*WidWidth +: WidWidth]       = tag_q[WidWidth-1:0];
    assign eu_operands_o[o*OpdWidth +: OpdWidth]      = data_q;

`ifndef SYNTHESIS
    a_rsp_requested : assert property (@(posedge clk_i) disable iff (rst_i)
      rf_rsp_valid_i[o] |-> (state_q == COLLECT && pend_q && req_q))
      else $error("rf response on port %0d without an outstanding request", o);
`endif
  end

  assign eu_valid_o         = (state_q == ISSUE);
  assign eu_tag_o           = tag_q;
  assign eu_pc_o            = pc_q;
  assign eu_act_mask_o      = act_mask_q;
  assign eu_inst_o          = inst_q;
  assign eu_dst_o           = dst_q;
  assign opc_eu_handshake_o = (state_q == ISSUE) && eu_ready_i;
  assign opc_eu_tag_o       = tag_q;

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector: immediate, dispatch latency, RF port
// independence, out-of-order responses, EU backpressure and async reset.
module tb_operand_collector;
  import bgpu_pkg::*;

  localparam int OPD = 1024;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          opc_ready_o;
  logic          disp_valid_i = 1'b0;
  logic [5:0]    disp_tag_i = '0;
  logic [31:0]   disp_pc_i = '0;
  logic [31:0]   disp_act_mask_i = '0;
  inst_t         disp_inst_i = '0;
  logic [5:0]    disp_dst_i = '0;
  logic [1:0]    disp_operands_is_reg_i = '0;
  logic [11:0]   disp_operands_i = '0;
  logic [1:0]    rf_req_valid_o;
  logic [1:0]    rf_req_ready_i = '0;
  logic [5:0]    rf_req_wid_o;
  logic [11:0]   rf_req_idx_o;
  logic [1:0]    rf_rsp_valid_i = '0;
  logic [2047:0] rf_rsp_data_i = '0;
  logic          eu_valid_o;
  logic          eu_ready_i = 1'b0;
  logic [5:0]    eu_tag_o;
  logic [31:0]   eu_pc_o;
  logic [31:0]   eu_act_mask_o;
  inst_t         eu_inst_o;
  logic [5:0]    eu_dst_o;
  logic [2047:0] eu_operands_o;
  logic          opc_eu_handshake_o;
  logic [5:0]    opc_eu_tag_o;

  int checks = 0;
  int errors = 0;

  operand_collector dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .opc_ready_o            (opc_ready_o),
    .disp_valid_i           (disp_valid_i),
    .disp_tag_i             (disp_tag_i),
    .disp_pc_i              (disp_pc_i),
    .disp_act_mask_i        (disp_act_mask_i),
    .disp_inst_i            (disp_inst_i),
    .disp_dst_i             (disp_dst_i),
    .disp_operands_is_reg_i (disp_operands_is_reg_i),
    .disp_operands_i        (disp_operands_i),
    .rf_req_valid_o         (rf_req_valid_o),
    .rf_req_ready_i         (rf_req_ready_i),
    .rf_req_wid_o           (rf_req_wid_o),
    .rf_req_idx_o           (rf_req_idx_o),
    .rf_rsp_valid_i         (rf_rsp_valid_i),
    .rf_rsp_data_i          (rf_rsp_data_i),
    .eu_valid_o             (eu_valid_o),
    .eu_ready_i             (eu_ready_i),
    .eu_tag_o               (eu_tag_o),
    .eu_pc_o                (eu_pc_o),
    .eu_act_mask_o          (eu_act_mask_o),
    .eu_inst_o              (eu_inst_o),
    .eu_dst_o               (eu_dst_o),
    .eu_operands_o          (eu_operands_o),
    .opc_eu_handshake_o     (opc_eu_handshake_o),
    .opc_eu_tag_o           (opc_eu_tag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_opd(input string tag, input logic [OPD-1:0] obs, input logic [OPD-1:0] exp);
    for (int c = 0; c < 4; c++)
      check($sformatf("%s[%0d]", tag, c), obs[c*256 +: 256], exp[c*256 +: 256]);
  endtask

  function automatic logic [OPD-1:0] pat(input logic [31:0] base, input logic [31:0] stride);
    logic [OPD-1:0] r;
    for (int t = 0; t < 32; t++) r[t*32 +: 32] = base + stride * t;
    return r;
  endfunction

  task automatic dispatch(input logic [5:0] tag, input logic [1:0] is_reg,
                          input logic [5:0] op1, input logic [5:0] op0);
    disp_tag_i             = tag;
    disp_pc_i              = 32'h1000_0000 | {26'd0, tag};
    disp_act_mask_i        = 32'hF0F0_0000 | {26'd0, tag};
    disp_inst_i            = '{eu: 4'h2, subtype: {2'b00, tag}};
    disp_dst_i             = ~tag;
    disp_operands_is_reg_i = is_reg;
    disp_operands_i        = {op1, op0};
    disp_valid_i           = 1'b1;
    step();
    disp_valid_i           = 1'b0;
  endtask

  logic [OPD-1:0] d0, d1, d2, d3;
  logic [5:0]     saved_tag;

  initial begin
    d0 = pat(32'hA000_0000, 32'd1);
    d1 = pat(32'hB000_0000, 32'd3);
    d2 = pat(32'hC100_0007, 32'd5);
    d3 = pat(32'hD200_0001, 32'd7);

    // Reset state
    step();
    step();
    check("rst_opc_ready", opc_ready_o, 1'b1);
    check("rst_eu_valid", eu_valid_o, 1'b0);
    check("rst_rf_req_valid", rf_req_valid_o, 2'b00);
    check("rst_handshake", opc_eu_handshake_o, 1'b0);
    check("rst_eu_tag", eu_tag_o, 6'h00);
    check_opd("rst_opd0", eu_operands_o[0 +: OPD], '0);
    rst_i = 1'b0;
    step();

    // Immediate operands only: issue after one edge
    eu_ready_i = 1'b1;
    #1;
    check("idle_no_handshake", opc_eu_handshake_o, 1'b0);
    eu_ready_i = 1'b0;
    dispatch(6'h15, 2'b00, 6'd5, 6'd3);
    check("t1_eu_valid", eu_valid_o, 1'b1);
    check("t1_opc_ready", opc_ready_o, 1'b0);
    check("t1_rf_req_valid", rf_req_valid_o, 2'b00);
    check("t1_eu_tag", eu_tag_o, 6'h15);
    check("t1_eu_pc", eu_pc_o, 32'h1000_0015);
    check("t1_eu_mask", eu_act_mask_o, 32'hF0F0_0015);
    check("t1_eu_inst", eu_inst_o, 12'h215);
    check("t1_eu_dst", eu_dst_o, 6'h2A);
    check_opd("t1_opd0", eu_operands_o[0 +: OPD], {32{32'd3}});
    check_opd("t1_opd1", eu_operands_o[OPD +: OPD], {32{32'd5}});
    eu_ready_i = 1'b1;
    #1;
    check("t1_handshake", opc_eu_handshake_o, 1'b1);
    check("t1_hs_tag", opc_eu_tag_o, 6'h15);
    step();
    eu_ready_i = 1'b0;
    #1;
    check("t1_back_idle", opc_ready_o, 1'b1);
    check("t1_valid_drop", eu_valid_o, 1'b0);
    check("t1_hs_drop", opc_eu_handshake_o, 1'b0);

    // Two register operands, RF ready, response latency 2
    rf_req_ready_i = 2'b11;
    dispatch(6'h0B, 2'b11, 6'd7, 6'd9);
    check("t2_req_valid", rf_req_valid_o, 2'b11);
    check("t2_req_idx", rf_req_idx_o, {6'd7, 6'd9});
    check("t2_req_wid", rf_req_wid_o, {3'd3, 3'd3});
    check("t2_eu_valid_c1", eu_valid_o, 1'b0);
    step();
    check("t2_req_done", rf_req_valid_o, 2'b00);
    step();
    rf_rsp_valid_i = 2'b11;
    rf_rsp_data_i  = {d1, d0};
    step();
    rf_rsp_valid_i = 2'b00;
    rf_rsp_data_i  = '0;
    check("t2_eu_valid_c3", eu_valid_o, 1'b0);
    step();
    check("t2_eu_valid_c4", eu_valid_o, 1'b1);
    check_opd("t2_opd0", eu_operands_o[0 +: OPD], d0);
    check_opd("t2_opd1", eu_operands_o[OPD +: OPD], d1);
    eu_ready_i = 1'b1;
    step();
    eu_ready_i = 1'b0;

    // Port 1 stalled by RF while port 0 completes on its own
    rf_req_ready_i = 2'b01;
    dispatch(6'h22, 2'b11, 6'd12, 6'd4);
    check("t3_req_both", rf_req_valid_o, 2'b11);
    step();
    check("t3_req_p1_only", rf_req_valid_o, 2'b10);
    rf_rsp_valid_i = 2'b01;
    rf_rsp_data_i  = {d3, d2};
    for (int i = 0; i < 4; i++) begin
      step();
      rf_rsp_valid_i = 2'b00;
      check($sformatf("t3_hold_valid%0d", i), rf_req_valid_o, 2'b10);
      check($sformatf("t3_hold_idx%0d", i), rf_req_idx_o[11:6], 6'd12);
      check($sformatf("t3_wait%0d", i), eu_valid_o, 1'b0);
    end
    rf_req_ready_i = 2'b11;
    step();
    rf_req_ready_i = 2'b00;
    check("t3_p1_accepted", rf_req_valid_o, 2'b00);
    rf_rsp_valid_i = 2'b10;
    step();
    rf_rsp_valid_i = 2'b00;
    check("t3_eu_valid_pre", eu_valid_o, 1'b0);
    step();
    check("t3_eu_valid", eu_valid_o, 1'b1);
    check_opd("t3_opd0", eu_operands_o[0 +: OPD], d2);
    check_opd("t3_opd1", eu_operands_o[OPD +: OPD], d3);
    eu_ready_i = 1'b1;
    step();
    eu_ready_i = 1'b0;

    // Out-of-order responses, then EU backpressure
    rf_req_ready_i = 2'b11;
    dispatch(6'h31, 2'b11, 6'd1, 6'd2);
    step();
    rf_req_ready_i = 2'b00;
    rf_rsp_valid_i = 2'b10;
    rf_rsp_data_i  = {d0, d3};
    step();
    check("t4_after_p1", eu_valid_o, 1'b0);
    rf_rsp_valid_i = 2'b01;
    rf_rsp_data_i  = {d2, d1};
    step();
    rf_rsp_valid_i = 2'b00;
    rf_rsp_data_i  = '0;
    check("t4_after_p0", eu_valid_o, 1'b0);
    step();
    check("t4_eu_valid", eu_valid_o, 1'b1);
    check_opd("t4_opd0", eu_operands_o[0 +: OPD], d1);
    check_opd("t4_opd1", eu_operands_o[OPD +: OPD], d0);
    saved_tag = 6'h31;
    disp_valid_i = 1'b1;
    disp_tag_i   = 6'h01;
    disp_operands_is_reg_i = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t5_valid%0d", i), eu_valid_o, 1'b1);
      check($sformatf("t5_ready%0d", i), opc_ready_o, 1'b0);
      check($sformatf("t5_hs%0d", i), opc_eu_handshake_o, 1'b0);
      check($sformatf("t5_tag%0d", i), eu_tag_o, saved_tag);
      check($sformatf("t5_opd1_%0d", i), eu_operands_o[OPD +: 256], d0[255:0]);
    end
    disp_valid_i = 1'b0;
    eu_ready_i = 1'b1;
    #1;
    check("t5_handshake", opc_eu_handshake_o, 1'b1);
    check("t5_hs_tag", opc_eu_tag_o, saved_tag);
    step();
    eu_ready_i = 1'b0;
    #1;
    check("t5_hs_once", opc_eu_handshake_o, 1'b0);
    check("t5_idle", opc_ready_o, 1'b1);

    // Async reset while collecting
    rf_req_ready_i = 2'b00;
    dispatch(6'h2E, 2'b11, 6'd20, 6'd21);
    check("t6_collecting", rf_req_valid_o, 2'b11);
    rst_i = 1'b1;
    #1;
    check("t6_rst_ready", opc_ready_o, 1'b1);
    check("t6_rst_req", rf_req_valid_o, 2'b00);
    check("t6_rst_eu_valid", eu_valid_o, 1'b0);
    check("t6_rst_tag", eu_tag_o, 6'h00);
    eu_ready_i = 1'b1;
    #1;
    check("t6_rst_hs", opc_eu_handshake_o, 1'b0);
    eu_ready_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();
    dispatch(6'h3C, 2'b00, 6'd1, 6'd63);
    check("t6_eu_valid", eu_valid_o, 1'b1);
    check("t6_eu_tag", eu_tag_o, 6'h3C);
    check_opd("t6_opd0", eu_operands_o[0 +: OPD], {32{32'd63}});
    check_opd("t6_opd1", eu_operands_o[OPD +: OPD], {32{32'd1}});
    eu_ready_i = 1'b1;
    #1;
    check("t6_handshake", opc_eu_handshake_o, 1'b1);
    check("t6_hs_tag", opc_eu_tag_o, 6'h3C);
    step();
    eu_ready_i = 1'b0;
    #1;
    check("t6_idle", opc_ready_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
